// File: rtl/sprite_animator_pkg.sv
// Shared screen geometry, sequencer state encoding and the player-2 tint
// used by the sprite engine.
package sprite_animator_pkg;

   localparam int          SCR_W       = 96;
   localparam int          SCR_H       = 64;
   localparam logic [15:0] TRANSPARENT = 16'hFFFF;

   typedef enum logic {
      SEQ_PLAY = 1'b0,
      SEQ_HOLD = 1'b1
   } seq_state_e;

   // Halve the green channel of an RGB565 pixel; the transparent key is never altered.
   function automatic logic [15:0] tint_rgb565(input logic [15:0] c, input logic en);
      logic [15:0] r;
      r = c;
      if (en && (c != TRANSPARENT)) begin
         r[10:5] = {1'b0, c[10:6]};
      end
      return r;
   endfunction

endpackage

// File: rtl/sprite_animator_if.sv
// Control, scan and ROM signals between one sprite engine and its surroundings.
interface sprite_animator_if #(
   parameter int NUM_ANIM   = 4,
   parameter int MAX_FRAMES = 4,
   parameter int SPR_W      = 32,
   parameter int SPR_H      = 32
);
   localparam int ANIM_W  = (NUM_ANIM > 1) ? $clog2(NUM_ANIM) : 1;
   localparam int FRAME_W = (MAX_FRAMES > 1) ? $clog2(MAX_FRAMES) : 1;
   localparam int AW      = $clog2(NUM_ANIM * MAX_FRAMES * SPR_W * SPR_H);

   logic               frame_tick;
   logic [ANIM_W-1:0]  anim_sel;
   logic               anim_start;
   logic [6:0]         x;
   logic [6:0]         y;
   logic               mirror;
   logic               modify_col;
   logic [12:0]        pixel_index;
   logic               pix_valid;
   logic [AW-1:0]      rom_addr;
   logic [15:0]        rom_data;
   logic [15:0]        oled_colour;
   logic               colour_valid;
   logic [ANIM_W-1:0]  cur_anim;
   logic [FRAME_W-1:0] cur_frame;
   logic               anim_done;

   modport master (
      output frame_tick, anim_sel, anim_start, x, y, mirror, modify_col,
             pixel_index, pix_valid, rom_data,
      input  rom_addr, oled_colour, colour_valid, cur_anim, cur_frame, anim_done
   );

   modport slave (
      input  frame_tick, anim_sel, anim_start, x, y, mirror, modify_col,
             pixel_index, pix_valid, rom_data,
      output rom_addr, oled_colour, colour_valid, cur_anim, cur_frame, anim_done
   );

endinterface

// File: rtl/sprite_animator_xform.sv
// Combinational scan-to-sprite mapping: translate, optional horizontal mirror,
// box test and sprite-ROM address for the current (anim, frame).
module sprite_xform
   import sprite_animator_pkg::*;
#(
   parameter int MAX_FRAMES = 4,
   parameter int SPR_W      = 32,
   parameter int SPR_H      = 32,
   parameter int ANIM_W     = 2,
   parameter int FRAME_W    = 2,
   parameter int AW         = 14
) (
   input  logic [12:0]        i_pixel_index,
   input  logic [6:0]         i_x,
   input  logic [6:0]         i_y,
   input  logic               i_mirror,
   input  logic [ANIM_W-1:0]  i_anim,
   input  logic [FRAME_W-1:0] i_frame,
   output logic               o_in_box,
   output logic [AW-1:0]      o_addr
);

   localparam logic signed [13:0] HALF_W  = 14'(SPR_W / 2);
   localparam logic signed [13:0] HALF_H  = 14'(SPR_H / 2);
   localparam logic signed [13:0] LAST_X  = 14'(SPR_W - 1);
   localparam logic signed [13:0] BOX_W   = 14'(SPR_W);
   localparam logic signed [13:0] BOX_H   = 14'(SPR_H);

   logic [12:0]        w_row;
   logic [12:0]        w_col;
   logic signed [13:0] w_sx_raw;
   logic signed [13:0] w_sx;
   logic signed [13:0] w_sy;
   logic [31:0]        w_base;
   logic [31:0]        w_off;

   assign w_row    = i_pixel_index / 13'(SCR_W);
   assign w_col    = i_pixel_index - (w_row * 13'(SCR_W));

   // Sprite centre maps to (SPR_W/2, SPR_H/2) in sprite coordinates.
   assign w_sx_raw = $signed({1'b0, w_col}) - $signed({7'd0, i_x}) + HALF_W;
   assign w_sy     = $signed({1'b0, w_row}) - $signed({7'd0, i_y}) + HALF_H;
   assign w_sx     = i_mirror ? (LAST_X - w_sx_raw) : w_sx_raw;

   assign o_in_box = (w_sx >= 0) && (w_sx < BOX_W) && (w_sy >= 0) && (w_sy < BOX_H);

   assign w_base   = 32'((32'(i_anim) * MAX_FRAMES + 32'(i_frame)) * SPR_W * SPR_H);
   assign w_off    = 32'(w_sy) * SPR_W + 32'(w_sx);
   assign o_addr   = o_in_box ? AW'(w_base + w_off) : '0;

endmodule

// File: rtl/sprite_animator.sv
// Per-fighter sprite engine: tick-driven animation sequencer feeding a
// one-pixel-per-cycle address / ROM / tint pipeline.
module sprite_animator
   import sprite_animator_pkg::*;
#(
   parameter int                    NUM_ANIM   = 4,
   parameter int                    MAX_FRAMES = 4,
   parameter logic [3*NUM_ANIM-1:0] ANIM_LEN   = {3'd3, 3'd3, 3'd3, 3'd2},
   parameter logic [NUM_ANIM-1:0]   ANIM_LOOP  = 4'b0001,
   parameter int                    SPR_W      = 32,
   parameter int                    SPR_H      = 32,
   parameter int                    ROM_LAT    = 1
) (
   input  logic               clk,
   input  logic               reset,
   sprite_animator_if.slave   bus
);

   localparam int ANIM_W  = (NUM_ANIM > 1) ? $clog2(NUM_ANIM) : 1;
   localparam int FRAME_W = (MAX_FRAMES > 1) ? $clog2(MAX_FRAMES) : 1;
   localparam int AW      = $clog2(NUM_ANIM * MAX_FRAMES * SPR_W * SPR_H);

   seq_state_e         r_state, w_state_nxt;
   logic [ANIM_W-1:0]  r_cur_anim, w_anim_nxt;
   logic [ANIM_W-1:0]  r_blk_sel, w_blk_sel_nxt;
   logic [FRAME_W-1:0] r_cur_frame, w_frame_nxt;
   logic               r_anim_done, w_done_nxt;
   logic               r_blocked, w_blocked_nxt;
   logic               w_blocked_now;
   logic               w_req;
   logic [2:0]         w_len;
   logic               w_loop;

   logic               w_in_box;
   logic [AW-1:0]      w_addr;
   logic               r_vld_p1;
   logic               r_inbox_p1;
   logic [AW-1:0]      r_addr_p1;
   logic               r_vld_p2   [ROM_LAT];
   logic               r_inbox_p2 [ROM_LAT];
   logic               r_vld_p3;
   logic [15:0]        r_colour_p3;

   // After a one-shot falls back to idle, the still-asserted old anim_sel must
   // not restart it; r_blocked remembers that until anim_sel moves or a start.
   always_comb begin
      w_len         = ANIM_LEN[3*int'(r_cur_anim) +: 3];
      w_loop        = ANIM_LOOP[r_cur_anim];
      w_blocked_now = r_blocked && (bus.anim_sel == r_blk_sel);
      w_req         = bus.anim_start || ((bus.anim_sel != r_cur_anim) && !w_blocked_now);
      w_state_nxt   = r_state;
      w_anim_nxt    = r_cur_anim;
      w_frame_nxt   = r_cur_frame;
      w_done_nxt    = 1'b0;
      w_blocked_nxt = w_blocked_now && !w_req;
      w_blk_sel_nxt = r_blk_sel;
      if (w_req) begin
         w_anim_nxt  = bus.anim_sel;
         w_frame_nxt = '0;
         w_state_nxt = SEQ_PLAY;
      end else if (bus.frame_tick) begin
         unique case (r_state)
            SEQ_PLAY: begin
               if (int'(r_cur_frame) < int'(w_len) - 1) begin
                  w_frame_nxt = r_cur_frame + FRAME_W'(1);
               end else if (w_loop) begin
                  w_frame_nxt = '0;
               end else begin
                  w_state_nxt = SEQ_HOLD;
               end
            end
            SEQ_HOLD: begin
               w_anim_nxt    = '0;
               w_frame_nxt   = '0;
               w_state_nxt   = SEQ_PLAY;
               w_done_nxt    = 1'b1;
               w_blocked_nxt = 1'b1;
               w_blk_sel_nxt = r_cur_anim;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= SEQ_PLAY;
         r_cur_anim  <= '0;
         r_cur_frame <= '0;
         r_anim_done <= 1'b0;
         r_blocked   <= 1'b0;
         r_blk_sel   <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_cur_anim  <= w_anim_nxt;
         r_cur_frame <= w_frame_nxt;
         r_anim_done <= w_done_nxt;
         r_blocked   <= w_blocked_nxt;
         r_blk_sel   <= w_blk_sel_nxt;
      end
   end

   sprite_xform #(
      .MAX_FRAMES (MAX_FRAMES),
      .SPR_W      (SPR_W),
      .SPR_H      (SPR_H),
      .ANIM_W     (ANIM_W),
      .FRAME_W    (FRAME_W),
      .AW         (AW)
   ) u_xform (
      .i_pixel_index (bus.pixel_index),
      .i_x           (bus.x),
      .i_y           (bus.y),
      .i_mirror      (bus.mirror),
      .i_anim        (r_cur_anim),
      .i_frame       (r_cur_frame),
      .o_in_box      (w_in_box),
      .o_addr        (w_addr)
   );

   // S1: ROM address register
   always_ff @(posedge clk) begin
      if (reset) begin
         r_vld_p1  <= 1'b0;
         r_addr_p1 <= '0;
      end else begin
         r_vld_p1  <= bus.pix_valid;
         r_addr_p1 <= w_addr;
      end
      r_inbox_p1 <= w_in_box;
   end

   // ROM: qualifiers ride alongside the ROM_LAT-cycle read
   always_ff @(posedge clk) begin
      r_inbox_p2[0] <= r_inbox_p1;
      for (int i = 1; i < ROM_LAT; i++) begin
         r_inbox_p2[i] <= r_inbox_p2[i-1];
      end
      if (reset) begin
         for (int i = 0; i < ROM_LAT; i++) begin
            r_vld_p2[i] <= 1'b0;
         end
      end else begin
         r_vld_p2[0] <= r_vld_p1;
         for (int i = 1; i < ROM_LAT; i++) begin
            r_vld_p2[i] <= r_vld_p2[i-1];
         end
      end
   end

   // S2: colour register
   always_ff @(posedge clk) begin
      if (reset) begin
         r_vld_p3    <= 1'b0;
         r_colour_p3 <= TRANSPARENT;
      end else begin
         r_vld_p3    <= r_vld_p2[ROM_LAT-1];
         r_colour_p3 <= r_inbox_p2[ROM_LAT-1] ? tint_rgb565(bus.rom_data, bus.modify_col)
                                              : TRANSPARENT;
      end
   end

   assign bus.rom_addr     = r_addr_p1;
   assign bus.oled_colour  = r_colour_p3;
   assign bus.colour_valid = r_vld_p3;
   assign bus.cur_anim     = r_cur_anim;
   assign bus.cur_frame    = r_cur_frame;
   assign bus.anim_done    = r_anim_done;

endmodule

// File: tb/tb_sprite_animator.sv
// Bench for sprite_animator: directed sequencer/pixel scenarios followed by a
// randomised run, both checked against a behavioural model of the engine.
module tb_sprite_animator;

   typedef struct {
      bit vld;
      bit inbox;
      int addr;
   } pent_t;

   logic clk;
   logic rst;

   sprite_animator_if #(.NUM_ANIM(4), .MAX_FRAMES(4), .SPR_W(32), .SPR_H(32)) bus ();

   sprite_animator #(
      .NUM_ANIM   (4),
      .MAX_FRAMES (4),
      .ANIM_LEN   ({3'd3, 3'd3, 3'd3, 3'd2}),
      .ANIM_LOOP  (4'b0001),
      .SPR_W      (32),
      .SPR_H      (32),
      .ROM_LAT    (1)
   ) dut (
      .clk   (clk),
      .reset (rst),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_total = 0;
   int n_pass  = 0;
   int n_fail  = 0;

   // behavioural model state
   int    LEN   [4] = '{2, 3, 3, 3};
   bit    LOOPS [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
   int    m_anim, m_frame, m_block_sel;
   bit    m_hold, m_block, m_done;
   pent_t h [3];
   int    last_addr;

   // stimulus state
   int         tx, ty;
   bit         tmir, tmod;
   logic [1:0] rsel;

   function automatic logic [15:0] rom_fn(input int a);
      if (a == 528) return 16'h07E0;
      if (a % 5 == 0) return 16'hFFFF;
      return 16'((a * 40503 + 12345) >> 3);
   endfunction

   function automatic logic [15:0] tint_ref(input logic [15:0] c, input bit en);
      int g;
      if (!en || c == 16'hFFFF) return c;
      g = (int'(c) / 32) % 64;
      return 16'(int'(c) - g * 32 + (g / 2) * 32);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock: drive inputs, advance the model, sample #1 after the edge, check.
   task automatic cyc(input bit r, input bit tick, input logic [1:0] sel, input bit start,
                      input int pix, input bit pv);
      pent_t pend;
      int    col, row, sx, sy;
      bit    blocked, req;
      rst             = r;
      bus.frame_tick  = tick;
      bus.anim_sel    = sel;
      bus.anim_start  = start;
      bus.pixel_index = 13'(pix);
      bus.pix_valid   = pv;
      bus.x           = 7'(tx);
      bus.y           = 7'(ty);
      bus.mirror      = tmir;
      bus.modify_col  = tmod;

      col = pix % 96;
      row = pix / 96;
      sx  = col - tx + 16;
      if (tmir) sx = 31 - sx;
      sy  = row - ty + 16;
      pend.vld   = pv;
      pend.inbox = (sx >= 0) && (sx < 32) && (sy >= 0) && (sy < 32);
      pend.addr  = pend.inbox ? ((m_anim * 4 + m_frame) * 1024 + sy * 32 + sx) : 0;

      if (r) begin
         m_anim = 0; m_frame = 0; m_hold = 0; m_block = 0; m_done = 0; m_block_sel = 0;
      end else begin
         m_done  = 0;
         blocked = m_block && (int'(sel) == m_block_sel);
         req     = start || ((int'(sel) != m_anim) && !blocked);
         m_block = blocked && !req;
         if (req) begin
            m_anim = int'(sel); m_frame = 0; m_hold = 0;
         end else if (tick) begin
            if (m_hold) begin
               m_block_sel = m_anim; m_block = 1;
               m_anim = 0; m_frame = 0; m_hold = 0; m_done = 1;
            end else if (m_frame < LEN[m_anim] - 1) begin
               m_frame++;
            end else if (LOOPS[m_anim]) begin
               m_frame = 0;
            end else begin
               m_hold = 1;
            end
         end
      end

      @(posedge clk);
      #1;
      bus.rom_data = rom_fn(last_addr);
      last_addr    = int'(bus.rom_addr);

      if (r) begin
         for (int i = 0; i < 3; i++) begin
            h[i].vld = 0; h[i].inbox = 0; h[i].addr = 0;
         end
      end else begin
         h[2] = h[1];
         h[1] = h[0];
         h[0] = pend;
      end

      chk("cur_anim",     32'(bus.cur_anim),     32'(m_anim));
      chk("cur_frame",    32'(bus.cur_frame),    32'(m_frame));
      chk("anim_done",    32'(bus.anim_done),    32'(m_done));
      chk("rom_addr",     32'(bus.rom_addr),     32'(h[0].addr));
      chk("colour_valid", 32'(bus.colour_valid), 32'(h[2].vld));
      if (r) begin
         chk("oled_colour_rst", 32'(bus.oled_colour), 32'h0000FFFF);
      end else if (h[2].vld) begin
         chk("oled_colour", 32'(bus.oled_colour),
             32'(h[2].inbox ? tint_ref(rom_fn(h[2].addr), tmod) : 16'hFFFF));
      end
   endtask

   initial begin
      int pix, row, col;
      tx = 48; ty = 32; tmir = 0; tmod = 0; rsel = 2'd0; last_addr = 0;
      bus.rom_data = 16'h0000;

      // reset state
      repeat (3) cyc(1, 0, 2'd0, 0, 0, 0);
      chk("rst_anim",   32'(bus.cur_anim),     32'd0);
      chk("rst_frame",  32'(bus.cur_frame),    32'd0);
      chk("rst_addr",   32'(bus.rom_addr),     32'd0);
      chk("rst_colour", 32'(bus.oled_colour),  32'h0000FFFF);
      chk("rst_cvalid", 32'(bus.colour_valid), 32'd0);

      // looping idle anim, length 2
      for (int i = 0; i < 5; i++) begin
         cyc(0, 1, 2'd0, 0, 0, 0);
         chk("loop_frame", 32'(bus.cur_frame), (i % 2 == 0) ? 32'd1 : 32'd0);
         chk("loop_done",  32'(bus.anim_done), 32'd0);
         cyc(0, 0, 2'd0, 0, 0, 0);
      end

      // one-shot anim 1, length 3
      cyc(0, 0, 2'd1, 0, 0, 0);
      chk("os_anim", 32'(bus.cur_anim), 32'd1);
      cyc(0, 1, 2'd1, 0, 0, 0);
      chk("os_f1", 32'(bus.cur_frame), 32'd1);
      cyc(0, 1, 2'd1, 0, 0, 0);
      chk("os_f2", 32'(bus.cur_frame), 32'd2);
      cyc(0, 1, 2'd1, 0, 0, 0);
      chk("os_hold_frame", 32'(bus.cur_frame), 32'd2);
      chk("os_hold_anim",  32'(bus.cur_anim),  32'd1);
      cyc(0, 1, 2'd1, 0, 0, 0);
      chk("os_done",      32'(bus.anim_done), 32'd1);
      chk("os_back_idle", 32'(bus.cur_anim),  32'd0);
      cyc(0, 0, 2'd1, 0, 0, 0);
      chk("os_done_pulse", 32'(bus.anim_done), 32'd0);
      chk("os_no_reenter", 32'(bus.cur_anim),  32'd0);

      // anim change beats a simultaneous tick
      cyc(0, 0, 2'd0, 0, 0, 0);
      cyc(0, 1, 2'd2, 0, 0, 0);
      chk("sel_pri_anim",  32'(bus.cur_anim),  32'd2);
      chk("sel_pri_frame", 32'(bus.cur_frame), 32'd0);

      // pixel path at anim 0 frame 0, sprite centred on (48,32)
      cyc(1, 0, 2'd0, 0, 0, 0);
      tmod = 1;
      cyc(0, 0, 2'd0, 0, 3120, 1);
      chk("pix_centre_addr", 32'(bus.rom_addr), 32'd528);
      cyc(0, 0, 2'd0, 0, 0, 1);
      chk("pix_oob_addr", 32'(bus.rom_addr), 32'd0);
      tmir = 1;
      cyc(0, 0, 2'd0, 0, 3120, 1);
      chk("pix_mirror_addr", 32'(bus.rom_addr),     32'd527);
      chk("pix_tint",        32'(bus.oled_colour),  32'h000003E0);
      chk("pix_tint_vld",    32'(bus.colour_valid), 32'd1);
      cyc(0, 0, 2'd0, 0, 0, 0);
      chk("pix_oob_colour",  32'(bus.oled_colour),  32'h0000FFFF);
      chk("pix_oob_vld",     32'(bus.colour_valid), 32'd1);
      cyc(0, 0, 2'd0, 0, 0, 0);
      cyc(0, 0, 2'd0, 0, 0, 0);
      chk("pix_drain_vld",   32'(bus.colour_valid), 32'd0);
      tmir = 0;

      // reset in the middle of a one-shot and a scan
      cyc(0, 0, 2'd1, 0, 3100, 1);
      cyc(0, 1, 2'd1, 0, 3101, 1);
      cyc(0, 0, 2'd1, 0, 3102, 1);
      cyc(1, 0, 2'd1, 0, 3103, 1);
      chk("mid_rst_anim",  32'(bus.cur_anim),     32'd0);
      chk("mid_rst_frame", 32'(bus.cur_frame),    32'd0);
      chk("mid_rst_vld",   32'(bus.colour_valid), 32'd0);
      cyc(0, 0, 2'd0, 0, 3104, 1);
      chk("refill_vld0", 32'(bus.colour_valid), 32'd0);
      cyc(0, 0, 2'd0, 0, 3105, 1);
      chk("refill_vld1", 32'(bus.colour_valid), 32'd0);
      cyc(0, 0, 2'd0, 0, 3106, 1);
      chk("refill_vld2", 32'(bus.colour_valid), 32'd1);

      // randomised run
      for (int k = 0; k < 600; k++) begin
         if ($urandom_range(0, 49) == 0) begin
            tx = $urandom_range(0, 95);
            ty = $urandom_range(0, 63);
            tmir = 1'($urandom_range(0, 1));
         end
         if ($urandom_range(0, 29) == 0) tmod = ~tmod;
         if ($urandom_range(0, 19) == 0) rsel = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 1) == 0) begin
            pix = $urandom_range(0, 6143);
         end else begin
            row = ty + $urandom_range(0, 40) - 20;
            col = tx + $urandom_range(0, 40) - 20;
            if (row < 0) row = 0;
            if (row > 63) row = 63;
            if (col < 0) col = 0;
            if (col > 95) col = 95;
            pix = row * 96 + col;
         end
         cyc($urandom_range(0, 199) == 0, $urandom_range(0, 3) == 0, rsel,
             $urandom_range(0, 39) == 0, pix, $urandom_range(0, 3) != 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
